// File: rtl/inst_bundle_queue.sv
`default_nettype none
// ============================================================================
//  Module      : inst_bundle_queue
//  Description : Circular instruction queue between fetch and decode. Accepts
//                up to three fetched instructions per cycle and presents the
//                three oldest entries to the ID stage, which consumes a prefix
//                of them (limited by rollback / stall). Flush squashes all.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_bundle_queue #(
  parameter int DEPTH = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [1:0]               fetch_count_i,
  input  logic [2:0][31:0]         fetch_inst_i,
  input  logic [2:0][31:0]         fetch_pc_i,
  output logic                     fetch_ready_o,
  input  logic [1:0]               rollback_i,
  input  logic                     stall_i,
  input  logic                     flush_i,
  output logic [2:0]               id_valid_o,
  output logic [2:0][31:0]         id_inst_o,
  output logic [2:0][31:0]         id_pc_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int          PTR_W = $clog2(DEPTH);
  localparam int          CNT_W = PTR_W + 1;
  localparam logic [31:0] C_NOP = 32'h0000_0013;

  // Storage: no reset, contents only meaningful where count says so
  logic [31:0]      mem_inst_q [DEPTH];
  logic [31:0]      mem_pc_q   [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fetch_ready_q, fetch_ready_d;

  logic [1:0]       n_valid;
  logic [1:0]       room;
  logic [1:0]       pop;
  logic [1:0]       push;
  logic [CNT_W-1:0] free_next;

  logic [PTR_W-1:0] rd_idx [3];
  logic [PTR_W-1:0] wr_idx [3];
  logic [2:0]       way_valid;

  // Per-way read/write addresses and presentation muxing
  for (genvar i = 0; i < 3; i++) begin : g_way
    assign rd_idx[i]     = head_q + PTR_W'(i);
    assign wr_idx[i]     = tail_q + PTR_W'(i);
    assign way_valid[i]  = (count_q > CNT_W'(i)) && !flush_i;
    assign id_inst_o[i]  = way_valid[i] ? mem_inst_q[rd_idx[i]] : C_NOP;
    assign id_pc_o[i]    = way_valid[i] ? mem_pc_q[rd_idx[i]]   : 32'h0;
  end

  assign id_valid_o    = way_valid;
  assign fetch_ready_o = fetch_ready_q;
  assign count_o       = count_q;

  // Push/pop amounts and next-state pointer/occupancy computation
  always_comb begin
    n_valid       = (count_q >= CNT_W'(3)) ? 2'd3 : count_q[1:0];
    room          = 2'd3 - rollback_i;
    pop           = 2'd0;
    push          = 2'd0;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fetch_ready_d = fetch_ready_q;
    free_next     = '0;

    if (!stall_i && !flush_i) begin
      pop = (n_valid < room) ? n_valid : room;
    end
    if (fetch_ready_q && !flush_i) begin
      push = fetch_count_i;
    end

    if (flush_i) begin
      // Flush wins over everything: empty queue, pointers back to zero
      head_d        = '0;
      tail_d        = '0;
      count_d       = '0;
      fetch_ready_d = 1'b1;
    end else begin
      head_d        = head_q + PTR_W'(pop);
      tail_d        = tail_q + PTR_W'(push);
      count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
      free_next     = CNT_W'(DEPTH) - count_d;
      // Ready is registered so fetch sees guaranteed room for a full bundle
      fetch_ready_d = (free_next >= CNT_W'(3));
    end
  end

  // Pointer, occupancy and ready registers with asynchronous reset
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      fetch_ready_q <= 1'b1;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      fetch_ready_q <= fetch_ready_d;
    end
  end

  // Write accepted fetch slots into consecutive entries starting at tail
  always_ff @(posedge clock_i) begin
    for (int j = 0; j < 3; j++) begin
      if (!reset_i && (j < int'(push))) begin
        mem_inst_q[wr_idx[j]] <= fetch_inst_i[j];
        mem_pc_q[wr_idx[j]]   <= fetch_pc_i[j];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_bundle_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_bundle_queue
//  Description : Directed self-checking bench for inst_bundle_queue (DEPTH 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_bundle_queue;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             clock_i;
  logic             reset_i;
  logic [1:0]       fetch_count_i;
  logic [2:0][31:0] fetch_inst_i;
  logic [2:0][31:0] fetch_pc_i;
  logic             fetch_ready_o;
  logic [1:0]       rollback_i;
  logic             stall_i;
  logic             flush_i;
  logic [2:0]       id_valid_o;
  logic [2:0][31:0] id_inst_o;
  logic [2:0][31:0] id_pc_o;
  logic [3:0]       count_o;

  int tests = 0;
  int fails = 0;

  inst_bundle_queue #(.DEPTH(8)) dut (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .fetch_count_i (fetch_count_i),
    .fetch_inst_i  (fetch_inst_i),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_ready_o (fetch_ready_o),
    .rollback_i    (rollback_i),
    .stall_i       (stall_i),
    .flush_i       (flush_i),
    .id_valid_o    (id_valid_o),
    .id_inst_o     (id_inst_o),
    .id_pc_o       (id_pc_o),
    .count_o       (count_o)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Instruction word tagged with its PC so inst/pc pairing is checkable
  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic set_in(input logic [1:0] fc, input logic [31:0] pc0,
                        input logic [1:0] rb, input logic st, input logic fl);
    fetch_count_i = fc;
    for (int j = 0; j < 3; j++) begin
      fetch_pc_i[j]   = pc0 + 32'(4 * j);
      fetch_inst_i[j] = inst_of(pc0 + 32'(4 * j));
    end
    rollback_i = rb;
    stall_i    = st;
    flush_i    = fl;
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    set_in(2'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    #2;
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", count_o); end
    tests++; if (fetch_ready_o !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", fetch_ready_o); end
    tests++; if (id_valid_o !== 3'b000) begin fails++; $display("FAIL reset_valid: got %b expected 000", id_valid_o); end
    tests++; if (id_inst_o[0] !== NOP) begin fails++; $display("FAIL reset_inst0: got %h expected %h", id_inst_o[0], NOP); end
    tests++; if (id_pc_o[0] !== 32'h0) begin fails++; $display("FAIL reset_pc0: got %h expected 0", id_pc_o[0]); end
    step();
    step();
    reset_i = 1'b0;
  endtask

  task automatic test_basic();
    set_in(2'd3, 32'h00, 2'd0, 1'b0, 1'b0);
    step();
    set_in(2'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    #1;
    tests++; if (id_valid_o !== 3'b111) begin fails++; $display("FAIL basic_valid: got %b expected 111", id_valid_o); end
    tests++; if (id_pc_o[0] !== 32'h00) begin fails++; $display("FAIL basic_pc0: got %h expected 00", id_pc_o[0]); end
    tests++; if (id_pc_o[1] !== 32'h04) begin fails++; $display("FAIL basic_pc1: got %h expected 04", id_pc_o[1]); end
    tests++; if (id_pc_o[2] !== 32'h08) begin fails++; $display("FAIL basic_pc2: got %h expected 08", id_pc_o[2]); end
    tests++; if (id_inst_o[2] !== 32'hC0DE_0008) begin fails++; $display("FAIL basic_inst2: got %h expected c0de0008", id_inst_o[2]); end
    step();
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL basic_drain_count: got %0d expected 0", count_o); end
    tests++; if (id_valid_o !== 3'b000) begin fails++; $display("FAIL basic_drain_valid: got %b expected 000", id_valid_o); end
  endtask

  task automatic test_rollback2();
    set_in(2'd3, 32'h10, 2'd0, 1'b0, 1'b0);
    step();
    set_in(2'd0, 32'h0, 2'd2, 1'b0, 1'b0);
    step();
    set_in(2'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    #1;
    tests++; if (count_o !== 4'd2) begin fails++; $display("FAIL rb2_count: got %0d expected 2", count_o); end
    tests++; if (id_valid_o !== 3'b011) begin fails++; $display("FAIL rb2_valid: got %b expected 011", id_valid_o); end
    tests++; if (id_pc_o[0] !== 32'h14) begin fails++; $display("FAIL rb2_pc0: got %h expected 14", id_pc_o[0]); end
    tests++; if (id_pc_o[1] !== 32'h18) begin fails++; $display("FAIL rb2_pc1: got %h expected 18", id_pc_o[1]); end
    tests++; if (id_inst_o[1] !== 32'hC0DE_0018) begin fails++; $display("FAIL rb2_inst1: got %h expected c0de0018", id_inst_o[1]); end
    tests++; if (id_inst_o[2] !== NOP) begin fails++; $display("FAIL rb2_inst2_nop: got %h expected %h", id_inst_o[2], NOP); end
    step();
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL rb2_drain: got %0d expected 0", count_o); end
  endtask

  // Head is at entry 6 here, so this bundle occupies entries 6, 7, 0
  task automatic test_wrap();
    set_in(2'd3, 32'h40, 2'd0, 1'b0, 1'b0);
    step();
    set_in(2'd0, 32'h0, 2'd3, 1'b0, 1'b0);
    #1;
    tests++; if (id_valid_o !== 3'b111) begin fails++; $display("FAIL wrap_valid: got %b expected 111", id_valid_o); end
    tests++; if (id_pc_o[0] !== 32'h40) begin fails++; $display("FAIL wrap_pc0: got %h expected 40", id_pc_o[0]); end
    tests++; if (id_pc_o[1] !== 32'h44) begin fails++; $display("FAIL wrap_pc1: got %h expected 44", id_pc_o[1]); end
    tests++; if (id_pc_o[2] !== 32'h48) begin fails++; $display("FAIL wrap_pc2: got %h expected 48", id_pc_o[2]); end
    step();
    tests++; if (count_o !== 4'd3) begin fails++; $display("FAIL wrap_rb3_count: got %0d expected 3", count_o); end
    tests++; if (id_pc_o[0] !== 32'h40) begin fails++; $display("FAIL wrap_rb3_pc0: got %h expected 40", id_pc_o[0]); end
    set_in(2'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    step();
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL wrap_drain: got %0d expected 0", count_o); end
  endtask

  task automatic test_stall_fill();
    set_in(2'd3, 32'h100, 2'd0, 1'b0, 1'b0);
    step();
    tests++; if (fetch_ready_o !== 1'b1) begin fails++; $display("FAIL fill_ready3: got %b expected 1", fetch_ready_o); end
    set_in(2'd3, 32'h110, 2'd0, 1'b1, 1'b0);
    step();
    tests++; if (count_o !== 4'd6) begin fails++; $display("FAIL fill_count6: got %0d expected 6", count_o); end
    tests++; if (fetch_ready_o !== 1'b0) begin fails++; $display("FAIL fill_ready6: got %b expected 0", fetch_ready_o); end
    for (int k = 0; k < 3; k++) begin
      set_in(2'd3, 32'h120, 2'd0, 1'b1, 1'b0);
      step();
      tests++; if (count_o !== 4'd6) begin fails++; $display("FAIL stall_count[%0d]: got %0d expected 6", k, count_o); end
      tests++; if (id_pc_o[0] !== 32'h100) begin fails++; $display("FAIL stall_pc0[%0d]: got %h expected 100", k, id_pc_o[0]); end
      tests++; if (id_pc_o[2] !== 32'h108) begin fails++; $display("FAIL stall_pc2[%0d]: got %h expected 108", k, id_pc_o[2]); end
    end
    set_in(2'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    step();
    tests++; if (count_o !== 4'd3) begin fails++; $display("FAIL fill_pop_count: got %0d expected 3", count_o); end
    tests++; if (fetch_ready_o !== 1'b1) begin fails++; $display("FAIL fill_pop_ready: got %b expected 1", fetch_ready_o); end
    tests++; if (id_pc_o[0] !== 32'h110) begin fails++; $display("FAIL fill_pop_pc0: got %h expected 110", id_pc_o[0]); end
    tests++; if (id_pc_o[2] !== 32'h118) begin fails++; $display("FAIL fill_pop_pc2: got %h expected 118", id_pc_o[2]); end
    step();
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL fill_drain: got %0d expected 0", count_o); end
  endtask

  task automatic test_back_to_back();
    set_in(2'd3, 32'h140, 2'd0, 1'b0, 1'b0);
    step();
    set_in(2'd3, 32'h150, 2'd0, 1'b0, 1'b0);
    step();
    tests++; if (count_o !== 4'd3) begin fails++; $display("FAIL b2b_count: got %0d expected 3", count_o); end
    tests++; if (id_pc_o[0] !== 32'h150) begin fails++; $display("FAIL b2b_pc0: got %h expected 150", id_pc_o[0]); end
    tests++; if (id_pc_o[1] !== 32'h154) begin fails++; $display("FAIL b2b_pc1: got %h expected 154", id_pc_o[1]); end
    set_in(2'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    step();
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL b2b_drain: got %0d expected 0", count_o); end
  endtask

  task automatic test_pop2();
    set_in(2'd2, 32'h20, 2'd0, 1'b0, 1'b0);
    step();
    set_in(2'd1, 32'h28, 2'd1, 1'b0, 1'b0);
    #1;
    tests++; if (id_valid_o !== 3'b011) begin fails++; $display("FAIL pop2_valid_pre: got %b expected 011", id_valid_o); end
    tests++; if (id_pc_o[1] !== 32'h24) begin fails++; $display("FAIL pop2_pc1_pre: got %h expected 24", id_pc_o[1]); end
    step();
    tests++; if (count_o !== 4'd1) begin fails++; $display("FAIL pop2_count: got %0d expected 1", count_o); end
    tests++; if (id_valid_o !== 3'b001) begin fails++; $display("FAIL pop2_valid: got %b expected 001", id_valid_o); end
    tests++; if (id_pc_o[0] !== 32'h28) begin fails++; $display("FAIL pop2_pc0: got %h expected 28", id_pc_o[0]); end
    set_in(2'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    step();
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL pop2_drain: got %0d expected 0", count_o); end
  endtask

  task automatic test_flush();
    set_in(2'd3, 32'h30, 2'd0, 1'b0, 1'b0);
    step();
    set_in(2'd2, 32'h3C, 2'd0, 1'b1, 1'b0);
    step();
    tests++; if (count_o !== 4'd5) begin fails++; $display("FAIL flush_pre_count: got %0d expected 5", count_o); end
    tests++; if (fetch_ready_o !== 1'b1) begin fails++; $display("FAIL flush_pre_ready: got %b expected 1", fetch_ready_o); end
    set_in(2'd3, 32'h50, 2'd0, 1'b0, 1'b1);
    #1;
    tests++; if (id_valid_o !== 3'b000) begin fails++; $display("FAIL flush_valid_now: got %b expected 000", id_valid_o); end
    tests++; if (id_inst_o[0] !== NOP) begin fails++; $display("FAIL flush_inst0_now: got %h expected %h", id_inst_o[0], NOP); end
    step();
    set_in(2'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    #1;
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL flush_count: got %0d expected 0", count_o); end
    tests++; if (fetch_ready_o !== 1'b1) begin fails++; $display("FAIL flush_ready: got %b expected 1", fetch_ready_o); end
    tests++; if (id_valid_o !== 3'b000) begin fails++; $display("FAIL flush_valid_next: got %b expected 000", id_valid_o); end
    set_in(2'd1, 32'h60, 2'd0, 1'b0, 1'b0);
    step();
    tests++; if (count_o !== 4'd1) begin fails++; $display("FAIL flush_repush_count: got %0d expected 1", count_o); end
    tests++; if (id_pc_o[0] !== 32'h60) begin fails++; $display("FAIL flush_repush_pc0: got %h expected 60", id_pc_o[0]); end
    set_in(2'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_async_reset();
    set_in(2'd3, 32'h70, 2'd0, 1'b0, 1'b0);
    step();
    set_in(2'd3, 32'h80, 2'd0, 1'b0, 1'b0);
    #2;
    reset_i = 1'b1;
    #1;
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL areset_count: got %0d expected 0", count_o); end
    tests++; if (id_valid_o !== 3'b000) begin fails++; $display("FAIL areset_valid: got %b expected 000", id_valid_o); end
    step();
    tests++; if (count_o !== 4'd0) begin fails++; $display("FAIL areset_hold_count: got %0d expected 0", count_o); end
    tests++; if (fetch_ready_o !== 1'b1) begin fails++; $display("FAIL areset_ready: got %b expected 1", fetch_ready_o); end
    reset_i = 1'b0;
    set_in(2'd1, 32'h90, 2'd0, 1'b0, 1'b0);
    step();
    tests++; if (count_o !== 4'd1) begin fails++; $display("FAIL areset_push_count: got %0d expected 1", count_o); end
    tests++; if (id_pc_o[0] !== 32'h90) begin fails++; $display("FAIL areset_push_pc0: got %h expected 90", id_pc_o[0]); end
    set_in(2'd0, 32'h0, 2'd0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rollback2();
    test_wrap();
    test_stall_fill();
    test_back_to_back();
    test_pop2();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_bundle_queue.md
INST_BUNDLE_QUEUE -- requirements
Module: inst_bundle_queue

Interface
REQ-001 Parameter: DEPTH, 8, queue entries; power of two, minimum 4.
REQ-002 clock  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-004 fetch_count  input  2  number of valid fetch slots this cycle (0-3); slots 0..fetch_count-1 valid, slot 0 oldest.
REQ-005 fetch_inst  input  3x32  fetched instructions, slot-indexed.
REQ-006 fetch_pc  input  3x32  PCs of fetched instructions, slot-indexed.
REQ-007 fetch_ready  output  1  registered; high when free entries >= 3.
REQ-008 rollback  input  2  from detection unit; number of youngest presented ways (way 2 downward) not consumed this cycle.
REQ-009 stall  input  1  ID stage holds; nothing consumed.
REQ-010 flush  input  1  squash entire queue (mispredict / exception).
REQ-011 id_valid  output  3  per-way valid; way 0 oldest.
REQ-012 id_inst  output  3x32  presented instructions, way-indexed.
REQ-013 id_pc  output  3x32  presented PCs, way-indexed.
REQ-014 count  output  log2(DEPTH)+1  registered occupancy.

Function
REQ-015 Storage: circular buffer, DEPTH entries of {inst, pc}; head = oldest, tail = next free; pointers wrap modulo DEPTH.
REQ-016 Presentation (combinational from state): way i shows entry (head+i) mod DEPTH; id_valid[i] = (count > i) and not flush.
REQ-017 Invalid ways: id_inst = 32'h0000_0013 (NOP), id_pc = 0.
REQ-018 n_valid = min(count, 3).
REQ-019 pop = 0 if stall or flush; otherwise min(n_valid, 3 - rollback).
REQ-020 rollback = 3 with stall = 0: pop = 0, same entries re-presented next cycle.
REQ-021 push = fetch_count if fetch_ready and not flush; otherwise 0. Slots offered while fetch_ready = 0 are dropped; upstream holds.
REQ-022 Push writes slot j to entry (tail+j) mod DEPTH for j < push; tail advances by push.
REQ-023 head advances by pop; count_next = count + push - pop; push and pop in the same cycle both take effect.
REQ-024 fetch_ready_next = (DEPTH - count_next >= 3); no combinational path from any input to fetch_ready.
REQ-025 Overflow impossible by REQ-024; underflow impossible by REQ-019.
REQ-026 flush has priority over push, pop, stall and rollback; next state head = tail = 0, count = 0, fetch_ready = 1.
REQ-027 Entries re-presented after rollback keep original inst/pc and way order; oldest unconsumed entry always moves to way 0.
REQ-028 Latency: an instruction pushed at edge N is presentable in the cycle after edge N (1-cycle fetch-to-ID).
REQ-029 Storage contents are don't-care when not valid; only pointers, count and fetch_ready are reset.

Reset
REQ-030 On reset assertion, asynchronously: head = 0, tail = 0, count = 0, fetch_ready = 1; id_valid = 3'b000 with NOP/0 outputs.
REQ-031 Reset asserted mid-operation discards all entries; the first push after deassertion lands in entry 0.
REQ-032 No push or pop occurs on an edge while reset is high.

Verification
REQ-033 After reset, push 3 (PCs 0x00, 0x04, 0x08), rollback 0 -> next cycle id_valid 111 with those PCs; following cycle (no push) count 0, id_valid 000.
REQ-034 count 3, PCs 0x10/0x14/0x18, rollback 2 -> pop 1; next cycle way 0 = 0x14, way 1 = 0x18, id_valid = 011 (no push).
REQ-035 count 3, rollback 3 or stall 1 for 4 cycles -> outputs unchanged, count 3; with push 3 each cycle, DEPTH = 8: fetch_ready drops once count >= 6.
REQ-036 Wrap: DEPTH 8, head = 6, count = 0; push 3 (PCs 0x40, 0x44, 0x48) -> entries 6, 7, 0; presented in order 0x40, 0x44, 0x48.
REQ-037 count 5, flush 1 with fetch_count 3 and rollback 0 -> id_valid 000 that cycle; next cycle count 0, fetch_ready 1, nothing pushed.
REQ-038 count 2 (PCs 0x20, 0x24), rollback 1 -> pop = min(2, 2) = 2; next cycle count 0 plus any same-cycle push.
